write_buffer: RTL and testbench

- Posted write buffer between the write-through cache and the backing RAM.
- Absorbs cache writes into a DEPTH-entry FIFO, acknowledges them immediately and drains them to memory in the background.
- Reads that hit a buffered address are forwarded from the buffer. Read misses bypass queued writes and go to memory first.

---
 rtl/wb_pkg.sv | 22 ++
 rtl/write_buffer_if.sv | 33 +++
 rtl/wb_fifo.sv | 101 ++++++++++
 rtl/write_buffer.sv | 150 +++++++++++++++
 tb/tb_write_buffer.sv | 295 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/wb_pkg.sv
// Shared types and constants for the posted write buffer.
// Default configuration; the write_buffer top takes matching parameters.
package wb_pkg;

  localparam int WB_DEPTH  = 4;
  localparam int WB_ADDR_W = 32;
  localparam int WB_DATA_W = 32;
  localparam int WB_PTR_W  = $clog2(WB_DEPTH);

  typedef logic [1:0] mem_state_t;

  localparam mem_state_t M_IDLE  = 2'd0;
  localparam mem_state_t M_WRITE = 2'd1;
  localparam mem_state_t M_READ  = 2'd2;
  localparam mem_state_t M_RWAIT = 2'd3;

  typedef struct packed {
    logic [WB_ADDR_W-1:0] addr;
    logic [WB_DATA_W-1:0] data;
  } wb_entry_t;

endpackage

// File: rtl/write_buffer_if.sv
// Cache-side request/response and memory-side bus of the write buffer.
// slave = the buffer, master = the cache/memory environment.
interface write_buffer_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) ();

  logic              req_valid;
  logic              req_wr;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_data;
  logic              req_ready;
  logic              resp_valid;
  logic [DATA_W-1:0] resp_data;
  logic              mem_valid;
  logic              mem_wr;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_data;
  logic              mem_ready;
  logic              mem_resp_valid;
  logic [DATA_W-1:0] mem_resp_data;

  modport slave (
    input  req_valid, req_wr, req_addr, req_data, mem_ready, mem_resp_valid, mem_resp_data,
    output req_ready, resp_valid, resp_data, mem_valid, mem_wr, mem_addr, mem_data
  );

  modport master (
    output req_valid, req_wr, req_addr, req_data, mem_ready, mem_resp_valid, mem_resp_data,
    input  req_ready, resp_valid, resp_data, mem_valid, mem_wr, mem_addr, mem_data
  );

endinterface

// File: rtl/wb_fifo.sv
// Circular write-buffer storage with in-place data update and a
// youngest-match associative address search.
module wb_fifo #(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push,
  input  logic [ADDR_W-1:0] push_addr,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  input  logic              upd,
  input  logic [PTR_W-1:0]  upd_idx,
  input  logic [DATA_W-1:0] upd_data,
  input  logic [ADDR_W-1:0] srch_addr,
  output logic              srch_hit,
  output logic [PTR_W-1:0]  srch_idx,
  output logic [DATA_W-1:0] srch_data,
  output logic [PTR_W-1:0]  head_idx,
  output logic [ADDR_W-1:0] head_addr,
  output logic [DATA_W-1:0] head_data,
  output logic [CNT_W-1:0]  count
);

  logic [ADDR_W-1:0] addr_q [DEPTH];
  logic [ADDR_W-1:0] addr_d [DEPTH];
  logic [DATA_W-1:0] data_q [DEPTH];
  logic [DATA_W-1:0] data_d [DEPTH];
  logic [PTR_W-1:0]  head_q, head_d, tail_q, tail_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [PTR_W-1:0]  idx_s;
  logic              match_s;

  always_comb begin
    addr_d  = addr_q;
    data_d  = data_q;
    head_d  = head_q;
    tail_d  = tail_q;
    if (upd) begin
      data_d[upd_idx] = upd_data;
    end else begin
      data_d[upd_idx] = data_q[upd_idx];
    end
    if (push) begin
      addr_d[tail_q] = push_addr;
      data_d[tail_q] = push_data;
      tail_d         = tail_q + PTR_W'(1);
    end else begin
      tail_d = tail_q;
    end
    if (pop) begin
      head_d = head_q + PTR_W'(1);
    end else begin
      head_d = head_q;
    end
    count_d = count_q + CNT_W'(push) - CNT_W'(pop);
  end

  // Scan oldest to youngest so the last match left standing is the youngest.
  always_comb begin
    srch_hit = 1'b0;
    srch_idx = head_q;
    idx_s    = head_q;
    match_s  = 1'b0;
    for (int k = 0; k < DEPTH; k++) begin
      idx_s    = head_q + PTR_W'(k);
      match_s  = (CNT_W'(k) < count_q) && (addr_q[idx_s] == srch_addr);
      srch_hit = srch_hit | match_s;
      srch_idx = match_s ? idx_s : srch_idx;
    end
  end

  assign srch_data = data_q[srch_idx];
  assign head_idx  = head_q;
  assign head_addr = addr_q[head_q];
  assign head_data = data_q[head_q];
  assign count     = count_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        addr_q[i] <= {ADDR_W{1'b0}};
        data_q[i] <= {DATA_W{1'b0}};
      end
      head_q  <= {PTR_W{1'b0}};
      tail_q  <= {PTR_W{1'b0}};
      count_q <= {CNT_W{1'b0}};
    end else begin
      addr_q  <= addr_d;
      data_q  <= data_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/write_buffer.sv
// Posted write buffer: acks writes at once, drains them in the background,
// forwards buffered reads. Optional macro WB_WRITE_MERGE_EN merges non-head writes.
module write_buffer
  import wb_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input logic           clk,
  input logic           rst_n,
  write_buffer_if.slave bus
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
`ifdef WB_WRITE_MERGE_EN
  localparam logic MERGE_EN = 1'b1;
`else
  localparam logic MERGE_EN = 1'b0;
`endif

  mem_state_t        state_q, state_d;
  logic              rd_pend_q, rd_pend_d;
  logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
  logic              resp_valid_q, resp_valid_d;
  logic [DATA_W-1:0] resp_data_q, resp_data_d;

  logic              srch_hit_s;
  logic [PTR_W-1:0]  srch_idx_s, head_idx_s;
  logic [DATA_W-1:0] srch_data_s, head_data_s;
  logic [ADDR_W-1:0] head_addr_s;
  logic [CNT_W-1:0]  count_s;
  logic              not_full_s, mergeable_s, accept_s, wr_acc_s, rd_acc_s;
  logic              merge_s, push_s, pop_s, rsp_in_s;

  // The head may already be on the memory bus, so it is never a merge target.
  assign not_full_s  = count_s < CNT_W'(DEPTH);
  assign mergeable_s = MERGE_EN && bus.req_wr && srch_hit_s && (srch_idx_s != head_idx_s);
  assign bus.req_ready = !rd_pend_q && (not_full_s || mergeable_s);

  assign accept_s = bus.req_valid && bus.req_ready;
  assign wr_acc_s = accept_s && bus.req_wr;
  assign rd_acc_s = accept_s && !bus.req_wr;
  assign merge_s  = wr_acc_s && mergeable_s;
  assign push_s   = wr_acc_s && !mergeable_s;
  assign pop_s    = (state_q == M_WRITE) && bus.mem_ready;
  assign rsp_in_s = (state_q == M_RWAIT) && bus.mem_resp_valid;

  wb_fifo #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push_s),
    .push_addr (bus.req_addr),
    .push_data (bus.req_data),
    .pop       (pop_s),
    .upd       (merge_s),
    .upd_idx   (srch_idx_s),
    .upd_data  (bus.req_data),
    .srch_addr (bus.req_addr),
    .srch_hit  (srch_hit_s),
    .srch_idx  (srch_idx_s),
    .srch_data (srch_data_s),
    .head_idx  (head_idx_s),
    .head_addr (head_addr_s),
    .head_data (head_data_s),
    .count     (count_s)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      M_IDLE: begin
        if (rd_pend_q) begin
          state_d = M_READ;
        end else if (count_s != CNT_W'(0)) begin
          state_d = M_WRITE;
        end else begin
          state_d = M_IDLE;
        end
      end
      M_WRITE: state_d = bus.mem_ready ? M_IDLE : M_WRITE;
      M_READ:  state_d = bus.mem_ready ? M_RWAIT : M_READ;
      M_RWAIT: state_d = bus.mem_resp_valid ? M_IDLE : M_RWAIT;
      default: state_d = M_IDLE;
    endcase
  end

  always_comb begin
    rd_pend_d    = rd_pend_q;
    rd_addr_d    = rd_addr_q;
    resp_valid_d = wr_acc_s || (rd_acc_s && srch_hit_s) || rsp_in_s;
    resp_data_d  = {DATA_W{1'b0}};
    if (rd_acc_s && !srch_hit_s) begin
      rd_pend_d = 1'b1;
      rd_addr_d = bus.req_addr;
    end else if (rsp_in_s) begin
      rd_pend_d = 1'b0;
    end else begin
      rd_pend_d = rd_pend_q;
    end
    if (rd_acc_s && srch_hit_s) begin
      resp_data_d = srch_data_s;
    end else if (rsp_in_s) begin
      resp_data_d = bus.mem_resp_data;
    end else begin
      resp_data_d = {DATA_W{1'b0}};
    end
  end

  always_comb begin
    bus.mem_valid = 1'b0;
    bus.mem_wr    = 1'b0;
    bus.mem_addr  = {ADDR_W{1'b0}};
    bus.mem_data  = {DATA_W{1'b0}};
    case (state_q)
      M_WRITE: begin
        bus.mem_valid = 1'b1;
        bus.mem_wr    = 1'b1;
        bus.mem_addr  = head_addr_s;
        bus.mem_data  = head_data_s;
      end
      M_READ: begin
        bus.mem_valid = 1'b1;
        bus.mem_addr  = rd_addr_q;
      end
      default: bus.mem_valid = 1'b0;
    endcase
  end

  assign bus.resp_valid = resp_valid_q;
  assign bus.resp_data  = resp_data_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= M_IDLE;
      rd_pend_q    <= 1'b0;
      rd_addr_q    <= {ADDR_W{1'b0}};
      resp_valid_q <= 1'b0;
      resp_data_q  <= {DATA_W{1'b0}};
    end else begin
      state_q      <= state_d;
      rd_pend_q    <= rd_pend_d;
      rd_addr_q    <= rd_addr_d;
      resp_valid_q <= resp_valid_d;
      resp_data_q  <= resp_data_d;
    end
  end

endmodule

// File: tb/tb_write_buffer.sv
// Scoreboard bench for write_buffer: a reference buffer model predicts
// responses, memory traffic, readiness and occupancy.
module tb_write_buffer;
  import wb_pkg::*;

  localparam int DEPTH = WB_DEPTH;
  localparam int AW    = WB_ADDR_W;
  localparam int DW    = WB_DATA_W;
`ifdef WB_WRITE_MERGE_EN
  localparam bit TB_MERGE = 1'b1;
`else
  localparam bit TB_MERGE = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  write_buffer_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();
  write_buffer #(.DEPTH(DEPTH), .ADDR_W(AW), .DATA_W(DW)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  typedef struct { logic [DW-1:0] data; int due; } exp_t;

  int          n_chk = 0;
  int          n_err = 0;
  int          cyc = 1;
  exp_t        exp_q[$];
  wb_entry_t   mdl_q[$];
  logic [AW:0] mem_log[$];
  bit          mdl_pend = 1'b0;
  logic [AW-1:0] mdl_pend_addr = '0;
  int          rsp_cnt = 0;
  logic [DW-1:0] rsp_val = '0;
  bit          stray = 1'b0;
  bit          prev_hold = 1'b0;
  logic        prev_wr = 1'b0;
  logic [AW-1:0] prev_addr = '0;
  logic [DW-1:0] prev_data = '0;
  bit          acc;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  function automatic logic [DW-1:0] mem_rd_val(input logic [AW-1:0] a);
    return (a == 32'h40) ? 32'h0000_DEAD : (a ^ 32'h5A5A_0000);
  endfunction

  // One clock: called just after a negedge with inputs set; checks and advances the model.
  task automatic step(output bit acc_o);
    int   hidx;
    bit   mrg, exp_rdy, fire;
    exp_t e;
    fire = 1'b0;
    bus.mem_resp_valid = 1'b0;
    bus.mem_resp_data  = '0;
    if (rsp_cnt > 0) begin
      rsp_cnt--;
      if (rsp_cnt == 0) begin
        bus.mem_resp_valid = 1'b1;
        bus.mem_resp_data  = rsp_val;
        fire = 1'b1;
      end
    end else if (stray) begin
      bus.mem_resp_valid = 1'b1;
      bus.mem_resp_data  = 32'hBAD0_BAD0;
      stray = 1'b0;
    end
    #1;
    if (exp_q.size() > 0 && exp_q[0].due == cyc && !bus.resp_valid) begin
      check("resp_missing", 64'd0, 64'd1);
      void'(exp_q.pop_front());
    end
    if (bus.resp_valid) begin
      if (exp_q.size() == 0) begin
        check("resp_spurious", 64'd1, 64'd0);
      end else begin
        e = exp_q.pop_front();
        check("resp_data", bus.resp_data, e.data);
        if (e.due != 0) check("resp_cycle", cyc, e.due);
      end
    end
    check("count", dut.u_fifo.count_q, mdl_q.size());
    if (prev_hold) begin
      check("mem_hold_valid", bus.mem_valid, 1);
      check("mem_hold_wr", bus.mem_wr, prev_wr);
      check("mem_hold_addr", bus.mem_addr, prev_addr);
      check("mem_hold_data", bus.mem_data, prev_data);
    end
    if (bus.mem_valid && bus.mem_wr) begin
      if (mdl_q.size() == 0) begin
        check("mem_wr_when_empty", 64'd1, 64'd0);
      end else begin
        check("mem_wr_addr", bus.mem_addr, mdl_q[0].addr);
        check("mem_wr_data", bus.mem_data, mdl_q[0].data);
      end
    end
    if (bus.mem_valid && !bus.mem_wr) begin
      check("mem_rd_pending", mdl_pend, 1);
      check("mem_rd_addr", bus.mem_addr, mdl_pend_addr);
    end
    prev_hold = bus.mem_valid && !bus.mem_ready;
    prev_wr   = bus.mem_wr;
    prev_addr = bus.mem_addr;
    prev_data = bus.mem_data;
    hidx = -1;
    foreach (mdl_q[i]) if (mdl_q[i].addr == bus.req_addr) hidx = i;
    mrg     = TB_MERGE && bus.req_wr && (hidx > 0);
    exp_rdy = !mdl_pend && ((mdl_q.size() < DEPTH) || mrg);
    if (bus.req_valid) check("req_ready", bus.req_ready, exp_rdy);
    acc_o = bus.req_valid && bus.req_ready;
    if (acc_o && bus.req_wr) begin
      if (mrg) mdl_q[hidx].data = bus.req_data;
      exp_q.push_back('{data: '0, due: cyc + 1});
    end else if (acc_o) begin
      if (hidx >= 0) begin
        exp_q.push_back('{data: mdl_q[hidx].data, due: cyc + 1});
      end else begin
        mdl_pend      = 1'b1;
        mdl_pend_addr = bus.req_addr;
        exp_q.push_back('{data: mem_rd_val(bus.req_addr), due: 0});
      end
    end
    if (bus.mem_valid && bus.mem_ready) begin
      mem_log.push_back({bus.mem_wr, bus.mem_addr});
      if (bus.mem_wr) begin
        if (mdl_q.size() > 0) void'(mdl_q.pop_front());
      end else begin
        rsp_cnt = 3;
        rsp_val = mem_rd_val(bus.mem_addr);
      end
    end
    if (acc_o && bus.req_wr && !mrg) mdl_q.push_back('{addr: bus.req_addr, data: bus.req_data});
    if (fire) mdl_pend = 1'b0;
    @(posedge clk);
    @(negedge clk);
    cyc++;
  endtask

  task automatic idle(input int n);
    bit a;
    bus.req_valid = 1'b0;
    for (int i = 0; i < n; i++) step(a);
  endtask

  task automatic send(input bit wr, input logic [AW-1:0] a, input logic [DW-1:0] d);
    bit done;
    done = 1'b0;
    bus.req_valid = 1'b1;
    bus.req_wr    = wr;
    bus.req_addr  = a;
    bus.req_data  = d;
    for (int i = 0; i < 50 && !done; i++) step(done);
    if (!done) check("send_timeout", 64'd0, 64'd1);
    bus.req_valid = 1'b0;
  endtask

  task automatic drain();
    bit a, done;
    done = 1'b0;
    bus.req_valid = 1'b0;
    bus.mem_ready = 1'b1;
    for (int i = 0; i < 200 && !done; i++) begin
      step(a);
      done = (mdl_q.size() == 0) && !mdl_pend && (exp_q.size() == 0) && (rsp_cnt == 0);
    end
    if (!done) check("drain_timeout", 64'd0, 64'd1);
    bus.mem_ready = 1'b0;
    idle(2);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.req_valid = 1'b0; bus.req_wr = 1'b0; bus.req_addr = '0; bus.req_data = '0;
    bus.mem_ready = 1'b0; bus.mem_resp_valid = 1'b0; bus.mem_resp_data = '0;
    repeat (2) @(negedge clk);
    check("rst_req_ready", bus.req_ready, 1);
    check("rst_mem_valid", bus.mem_valid, 0);
    check("rst_resp_valid", bus.resp_valid, 0);
    rst_n = 1'b1;
    idle(2);
    check("post_rst_req_ready", bus.req_ready, 1);

    // single write, memory stalled: immediate ack, stable memory request
    send(1'b1, 32'h10, 32'hAA);
    idle(5);
    check("t1_mem_valid", bus.mem_valid, 1);
    check("t1_mem_wr", bus.mem_wr, 1);
    check("t1_mem_addr", bus.mem_addr, 32'h10);
    check("t1_mem_data", bus.mem_data, 32'hAA);
    drain();

    // fill to DEPTH; a pop does not admit a write in the same cycle
    for (int i = 0; i < DEPTH; i++) send(1'b1, 32'h50 + 32'(4 * i), 32'h100 + 32'(i));
    idle(1);
    check("full_req_ready", bus.req_ready, 0);
    bus.mem_ready = 1'b1;
    bus.req_valid = 1'b1; bus.req_wr = 1'b1; bus.req_addr = 32'h60; bus.req_data = 32'h600;
    step(acc);
    check("full_pop_refused", acc, 0);
    bus.mem_ready = 1'b0;
    bus.req_valid = 1'b0;
    check("after_pop_ready", bus.req_ready, 1);
    send(1'b1, 32'h60, 32'h600);
    drain();

    // duplicate writes, read forwards the youngest, no memory read
    mem_log.delete();
    send(1'b1, 32'h20, 32'h11);
    send(1'b1, 32'h20, 32'h22);
    send(1'b0, 32'h20, 32'h0);
    check("fwd_resp_valid", bus.resp_valid, 1);
    check("fwd_resp_data", bus.resp_data, 32'h22);
    drain();
    begin
      int nrd;
      nrd = 0;
      foreach (mem_log[i]) if (!mem_log[i][AW]) nrd++;
      check("fwd_no_mem_read", nrd, 0);
    end

    // read miss overtakes a queued write
    mem_log.delete();
    send(1'b1, 32'h08, 32'h01);
    send(1'b1, 32'h10, 32'hAA);
    send(1'b0, 32'h40, 32'h0);
    idle(2);
    drain();
    check("prio_log_len", mem_log.size(), 3);
    if (mem_log.size() == 3) begin
      check("prio_first", mem_log[0], {1'b1, 32'h08});
      check("prio_read", mem_log[1], {1'b0, 32'h40});
      check("prio_drain", mem_log[2], {1'b1, 32'h10});
    end

    // stray memory response outside a read is ignored
    stray = 1'b1;
    idle(1);
    check("stray_no_resp", bus.resp_valid, 0);
    idle(2);

    // full buffer: merge of a non-head entry, head never merged
    send(1'b1, 32'h70, 32'h1);
    send(1'b1, 32'h74, 32'h2);
    send(1'b1, 32'h30, 32'h3);
    send(1'b1, 32'h78, 32'h4);
    idle(1);
    bus.req_valid = 1'b1; bus.req_wr = 1'b1; bus.req_addr = 32'h70; bus.req_data = 32'h77;
    step(acc);
    check("head_merge_refused", acc, 0);
`ifdef WB_WRITE_MERGE_EN
    send(1'b1, 32'h30, 32'h55);
    check("merge_count", dut.u_fifo.count_q, DEPTH);
    send(1'b0, 32'h30, 32'h0);
    check("merge_read", bus.resp_data, 32'h55);
`else
    bus.req_addr = 32'h30; bus.req_data = 32'h55;
    step(acc);
    check("nomerge_full_refused", acc, 0);
    bus.req_valid = 1'b0;
`endif
    drain();

    // asynchronous reset in the middle of a write drain
    send(1'b1, 32'h90, 32'h9);
    send(1'b1, 32'h94, 32'hA);
    idle(2);
    check("pre_rst_mem_valid", bus.mem_valid, 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_count", dut.u_fifo.count_q, 0);
    check("rst_mid_mem_valid", bus.mem_valid, 0);
    check("rst_mid_req_ready", bus.req_ready, 1);
    mdl_q.delete(); exp_q.delete();
    mdl_pend = 1'b0; rsp_cnt = 0; prev_hold = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    idle(4);
    check("post_rst_mem_valid", bus.mem_valid, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
